if_prefetch_buffer: RTL and testbench
=====================================

Name: if_prefetch_buffer

Overview:
Instruction-fetch front end that sits directly upstream of the pipeline core's If2Id stage. It replaces the combinational PcOut/InstIn path with a request/response instruction-memory port. It issues sequential fetch requests, buffers returned instructions in an in-order FIFO, and presents one instruction with its address to the core under a valid/ready handshake. A flush input redirects fetch to a new PC and discards stale in-flight responses.

Parameters:
DEPTH, 4, FIFO entries; also the maximum of (entries held + requests in flight); power of two, >= 2
ADDR_W, 64, address width (matches `AddrBus)
INST_W, 32, instruction width (matches `InstBus)
RESET_PC, 64'h8000_0000, fetch address after reset

Ports:
Clk  in  1  clock; all state updates on rising edge
Rst  in  1  asynchronous, active-high reset
MemReqValid  out  1  fetch request valid
MemReqAddr  out  ADDR_W  fetch address, word aligned
MemReqReady  in  1  memory accepts the request this cycle
MemRespValid  in  1  response data valid; responses return in request order
MemRespData  in  INST_W  returned instruction
InstValid  out  1  head instruction valid toward the core
InstData  out  INST_W  head instruction
InstAddr  out  ADDR_W  address of head instruction
InstReady  in  1  core consumes head this cycle
Flush  in  1  redirect request, single-cycle pulse
FlushPc  in  ADDR_W  redirect target

Behaviour:
- Reset (asynchronous, active-high, Clk and Rst as named above) sets:
  - FetchPc = RESET_PC and RespPc = RESET_PC.
  - FIFO count, read pointer, write pointer, InFlight and Discard = 0.
  - MemReqValid = 0 and InstValid = 0. InstData and InstAddr are don't-care while InstValid = 0.
- Credit rule: MemReqValid = !Flush && (count + InFlight < DEPTH). MemReqAddr = FetchPc.
- Request handshake: when MemReqValid && MemReqReady, FetchPc += 4 and InFlight += 1. MemReqAddr is held stable while the request is stalled.
- Response handling: MemRespValid always causes InFlight -= 1.
  - If Discard > 0, then Discard -= 1 and the data is dropped.
  - Otherwise the data is pushed as entry {MemRespData, RespPc} and RespPc += 4.
- Request and response in the same cycle: InFlight is unchanged.
- Output: InstValid = (count != 0). InstData and InstAddr come from the head entry.
- Pop: InstValid && InstReady pops the head. Push and pop in the same cycle leave count unchanged.
- Full: the credit rule guarantees a push never occurs while the FIFO is full. A response arriving when full is a protocol violation; flag it with an assertion.
- Empty: InstValid = 0, and InstReady is ignored.
- Flush, effective at the clock edge:
  - count = 0 and both pointers = 0.
  - FetchPc = FlushPc and RespPc = FlushPc.
  - Discard = InFlight - (MemRespValid ? 1 : 0); any response arriving in the flush cycle is itself dropped.
  - Pop and push in the flush cycle are ignored.
  - MemReqValid = 0 in the flush cycle, so no request is accepted. Requests resume the next cycle from FlushPc, still subject to the credit rule, since InFlight includes discarded requests.
- Flush while Discard > 0 simply recomputes Discard from the current InFlight.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Latency without the optional feature: a response that hits an empty FIFO gives InstValid = 1 on the next cycle.
- Reset asserted mid-operation discards everything immediately. Responses still arriving from memory after reset are the memory's responsibility; the memory is reset from the same Rst.

Optional Feature:
IFB_BYPASS_EN
- Defined: when count == 0, Discard == 0, MemRespValid && !Flush, the response is presented combinationally.
  - InstValid = 1, InstData = MemRespData, InstAddr = RespPc.
  - If InstReady is also high, the entry is not written to the FIFO; RespPc still advances.
  - Gives 0-cycle response-to-core latency.
- Undefined: no combinational path from Mem* inputs to Inst* outputs; latency is 1 cycle.

Test Plan:
- Reset then run with MemReqReady = 1, 1-cycle response latency, InstReady = 1 -> requests 0x8000_0000, _0004, _0008 ...; InstAddr follows the same sequence with the matching data.
- InstReady = 0, DEPTH = 4 -> exactly 4 requests are accepted, then MemReqValid = 0. Raising InstReady for one cycle -> exactly one new request is issued.
- Memory stall: MemReqReady = 0 for 5 cycles -> MemReqAddr is held at 0x8000_0000; no FetchPc advance.
- 3 requests in flight, Flush with FlushPc = 0x8000_0100, no response that cycle -> Discard = 3; the next 3 responses are dropped; the first InstAddr seen is 0x8000_0100.
- Flush coincident with MemRespValid and 2 in flight -> Discard = 1; that cycle's response is dropped, along with one more.
- Rst asserted mid-stream with 2 entries buffered -> InstValid = 0 and MemReqValid = 0 immediately, without a clock edge. After release, fetch restarts at 0x8000_0000.
- With IFB_BYPASS_EN: empty FIFO and a response arrives -> InstValid = 1 in the same cycle. Without it: InstValid = 1 one cycle later.

Source files
------------

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch prefetch buffer: issues sequential fetch requests to a
// request/response instruction memory, queues returned instructions in an
// in-order FIFO and hands them to the core under a valid/ready handshake.
// A flush redirects fetch and drops responses that were already in flight.
// Optional build macro IFB_BYPASS_EN: when the FIFO is empty and nothing is
// being discarded, a response is forwarded to the core in the same cycle.
module if_prefetch_buffer #(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              MemReqValid,
    output logic [ADDR_W-1:0] MemReqAddr,
    input  logic              MemReqReady,
    input  logic              MemRespValid,
    input  logic [INST_W-1:0] MemRespData,
    output logic              InstValid,
    output logic [INST_W-1:0] InstData,
    output logic [ADDR_W-1:0] InstAddr,
    input  logic              InstReady,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] FlushPc
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                CNT_W     = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

    logic [ADDR_W-1:0] fetchPc;
    logic [ADDR_W-1:0] respPc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  inFlight;
    logic [CNT_W-1:0]  discard;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;

    logic [INST_W-1:0] dataMem [DEPTH];
    logic [ADDR_W-1:0] addrMem [DEPTH];

    logic [CNT_W:0]    creditUsed;
    logic              reqFire;
    logic              fifoEmpty;
    logic              fifoFull;
    logic              respKeep;
    logic              bypassTake;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  respDec;

    // Buffered entries plus outstanding requests never exceed DEPTH, so every
    // response is guaranteed a free slot.
    assign creditUsed  = {1'b0, count} + {1'b0, inFlight};
    assign MemReqValid = !Rst && !Flush && (creditUsed < DEPTH_LIM);
    assign MemReqAddr  = fetchPc;
    assign reqFire     = MemReqValid && MemReqReady;

    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == FULL_CNT);
    assign respDec   = CNT_W'(MemRespValid);

    // A response is kept only when it is not owed to a discarded request and
    // is not arriving in a flush cycle.
    assign respKeep = MemRespValid && (discard == '0) && !Flush;

`ifdef IFB_BYPASS_EN
    logic bypassHit;

    assign bypassHit  = !Rst && fifoEmpty && respKeep;
    assign bypassTake = bypassHit && InstReady;
    assign InstValid  = !fifoEmpty || bypassHit;
    assign InstData   = fifoEmpty ? MemRespData : dataMem[rdPtr];
    assign InstAddr   = fifoEmpty ? respPc      : addrMem[rdPtr];
`else
    assign bypassTake = 1'b0;
    assign InstValid  = !fifoEmpty;
    assign InstData   = dataMem[rdPtr];
    assign InstAddr   = addrMem[rdPtr];
`endif

    assign push = respKeep && !bypassTake;
    assign pop  = !fifoEmpty && InstReady && !Flush;

    // Control state: fetch/response PCs, FIFO pointers, credit and discard counters.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fetchPc  <= RESET_PC;
            respPc   <= RESET_PC;
            count    <= '0;
            inFlight <= '0;
            discard  <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
        end else if (Flush) begin
            fetchPc  <= FlushPc;
            respPc   <= FlushPc;
            count    <= '0;
            rdPtr    <= '0;
            wrPtr    <= '0;
            inFlight <= inFlight - respDec;
            discard  <= inFlight - respDec;
        end else begin
            if (reqFire) begin
                fetchPc <= fetchPc + PC_STEP;
            end
            inFlight <= inFlight + CNT_W'(reqFire) - respDec;
            if (MemRespValid) begin
                if (discard != '0) begin
                    discard <= discard - 1'b1;
                end else begin
                    respPc <= respPc + PC_STEP;
                end
            end
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Entry storage holds only data, so it carries no reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            dataMem[wrPtr] <= MemRespData;
            addrMem[wrPtr] <= respPc;
        end
    end

`ifndef SYNTHESIS
    // A kept response into a full FIFO, or a response with nothing outstanding,
    // means the memory broke the request/response protocol.
    assert property (@(posedge Clk) disable iff (Rst) !(respKeep && fifoFull));
    assert property (@(posedge Clk) disable iff (Rst) !(MemRespValid && (inFlight == '0)));
`endif

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Directed bench for if_prefetch_buffer with a small in-order memory model
// (one-cycle response latency when auto-response is enabled).
module tb_if_prefetch_buffer;

    localparam int          ADDR_W = 64;
    localparam int          INST_W = 32;
    localparam logic [63:0] BASE   = 64'h8000_0000;
`ifdef IFB_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              MemReqValid;
    logic [ADDR_W-1:0] MemReqAddr;
    logic              MemReqReady = 1'b0;
    logic              MemRespValid = 1'b0;
    logic [INST_W-1:0] MemRespData = '0;
    logic              InstValid;
    logic [INST_W-1:0] InstData;
    logic [ADDR_W-1:0] InstAddr;
    logic              InstReady = 1'b0;
    logic              Flush = 1'b0;
    logic [ADDR_W-1:0] FlushPc = '0;

    if_prefetch_buffer #(
        .DEPTH   (4),
        .ADDR_W  (ADDR_W),
        .INST_W  (INST_W),
        .RESET_PC(BASE)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .MemReqValid (MemReqValid),
        .MemReqAddr  (MemReqAddr),
        .MemReqReady (MemReqReady),
        .MemRespValid(MemRespValid),
        .MemRespData (MemRespData),
        .InstValid   (InstValid),
        .InstData    (InstData),
        .InstAddr    (InstAddr),
        .InstReady   (InstReady),
        .Flush       (Flush),
        .FlushPc     (FlushPc)
    );

    always #5 Clk = ~Clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] pending[$];
    bit          autoResp   = 1'b0;
    int          reqCount   = 0;
    logic [63:0] lastReqAddr = '0;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dataOf(input logic [63:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // One clock: sample handshakes away from the edge, update the memory
    // model after the edge, then let combinational outputs settle.
    task automatic cycle();
        bit          fire;
        bit          rsp;
        logic [63:0] a;
        @(negedge Clk);
        fire = MemReqValid && MemReqReady;
        rsp  = MemRespValid;
        a    = MemReqAddr;
        @(posedge Clk);
        #1;
        if (rsp && pending.size() > 0) pending.delete(0);
        if (fire && !Rst) begin
            pending.push_back(a);
            reqCount++;
            lastReqAddr = a;
        end
        if (autoResp && pending.size() > 0) begin
            MemRespValid = 1'b1;
            MemRespData  = dataOf(pending[0]);
        end else begin
            MemRespValid = 1'b0;
        end
        #1;
    endtask

    task automatic doReset();
        Rst          = 1'b1;
        Flush        = 1'b0;
        MemReqReady  = 1'b0;
        InstReady    = 1'b0;
        autoResp     = 1'b0;
        MemRespValid = 1'b0;
        pending.delete();
        cycle();
        reqCount = 0;
        Rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit found;

        // Reset state and straight-line streaming
        #2;
        checkEq("rst.reqValid", MemReqValid, 0);
        checkEq("rst.instValid", InstValid, 0);
        cycle();
        Rst = 1'b0;
        #1;
        checkEq("rel.reqValid", MemReqValid, 1);
        checkEq("rel.reqAddr", MemReqAddr, BASE);
        checkEq("rel.instValid", InstValid, 0);
        MemReqReady = 1'b1;
        InstReady   = 1'b1;
        autoResp    = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            cycle();
            checkEq("stream.reqAddr", MemReqAddr, BASE + 64'(4 * n));
            if (n >= LAT) begin
                checkEq("stream.instValid", InstValid, 1);
                checkEq("stream.instAddr", InstAddr, BASE + 64'(4 * (n - LAT)));
                checkEq("stream.instData", InstData, dataOf(BASE + 64'(4 * (n - LAT))));
            end else begin
                checkEq("stream.early", InstValid, 0);
            end
        end

        // Credit limit with a stalled core
        doReset();
        MemReqReady = 1'b1;
        autoResp    = 1'b1;
        repeat (8) cycle();
        checkEq("credit.reqs", reqCount, 4);
        checkEq("credit.stop", MemReqValid, 0);
        checkEq("credit.head", InstAddr, BASE);
        InstReady = 1'b1;
        cycle();
        InstReady = 1'b0;
        #1;
        checkEq("credit.popHead", InstAddr, BASE + 64'h4);
        checkEq("credit.resume", MemReqValid, 1);
        repeat (4) cycle();
        checkEq("credit.reqs2", reqCount, 5);
        checkEq("credit.lastAddr", lastReqAddr, BASE + 64'h10);
        checkEq("credit.stop2", MemReqValid, 0);

        // Memory stall holds the request address
        doReset();
        autoResp = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cycle();
            checkEq("stall.addr", MemReqAddr, BASE);
            checkEq("stall.valid", MemReqValid, 1);
        end
        checkEq("stall.reqs", reqCount, 0);
        MemReqReady = 1'b1;
        cycle();
        checkEq("stall.advance", MemReqAddr, BASE + 64'h4);
        checkEq("stall.reqs1", reqCount, 1);

        // Flush with three requests in flight and no response that cycle
        doReset();
        MemReqReady = 1'b1;
        InstReady   = 1'b1;
        repeat (3) cycle();
        checkEq("flush3.reqs", reqCount, 3);
        Flush   = 1'b1;
        FlushPc = BASE + 64'h100;
        #1;
        checkEq("flush3.reqGate", MemReqValid, 0);
        cycle();
        Flush = 1'b0;
        #1;
        checkEq("flush3.reqAddr", MemReqAddr, BASE + 64'h100);
        checkEq("flush3.reqValid", MemReqValid, 1);
        checkEq("flush3.empty", InstValid, 0);
        autoResp = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            cycle();
            if (InstValid) begin
                found = 1'b1;
                checkEq("flush3.addr", InstAddr, BASE + 64'h100);
                checkEq("flush3.data", InstData, dataOf(BASE + 64'h100));
            end
        end
        checkEq("flush3.seen", found, 1);

        // Flush coincident with a response, two in flight
        doReset();
        MemReqReady = 1'b1;
        InstReady   = 1'b1;
        repeat (2) cycle();
        MemReqReady  = 1'b0;
        MemRespValid = 1'b1;
        MemRespData  = dataOf(pending[0]);
        Flush        = 1'b1;
        FlushPc      = BASE + 64'h200;
        #1;
        checkEq("flush2.noInst", InstValid, 0);
        cycle();
        Flush       = 1'b0;
        MemReqReady = 1'b1;
        autoResp    = 1'b1;
        #1;
        checkEq("flush2.reqAddr", MemReqAddr, BASE + 64'h200);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            cycle();
            if (InstValid) begin
                found = 1'b1;
                checkEq("flush2.addr", InstAddr, BASE + 64'h200);
                checkEq("flush2.data", InstData, dataOf(BASE + 64'h200));
            end
        end
        checkEq("flush2.seen", found, 1);

        // Asynchronous reset mid-stream with two entries buffered
        doReset();
        MemReqReady = 1'b1;
        autoResp    = 1'b1;
        repeat (3) cycle();
        checkEq("arst.pre", InstValid, 1);
        #2;
        Rst = 1'b1;
        #1;
        checkEq("arst.instValid", InstValid, 0);
        checkEq("arst.reqValid", MemReqValid, 0);
        pending.delete();
        autoResp     = 1'b0;
        MemRespValid = 1'b0;
        MemReqReady  = 1'b0;
        cycle();
        Rst = 1'b0;
        #1;
        checkEq("arst.relValid", MemReqValid, 1);
        checkEq("arst.relAddr", MemReqAddr, BASE);
        checkEq("arst.relEmpty", InstValid, 0);
        MemReqReady = 1'b1;
        autoResp    = 1'b1;
        InstReady   = 1'b1;
        repeat (LAT) cycle();
        checkEq("arst.restart", InstValid, 1);
        checkEq("arst.restartAddr", InstAddr, BASE);

        // Response-to-core latency on an empty FIFO
        doReset();
        MemReqReady = 1'b1;
        autoResp    = 1'b1;
        cycle();
        checkEq("lat.same", InstValid, BYP);
        cycle();
        checkEq("lat.next", InstValid, 1);
        checkEq("lat.addr", InstAddr, BASE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
